// File: rtl/tia_hphase_pkg.sv
// Shared types, constants and helpers for the TIA horizontal phase generator
// and the polynomial counters built on the same LFSR.
package tia_hphase_pkg;

  localparam int HC_W = 6;

  // XNOR-feedback shift: all-zero is a legal state, all-ones is the lock-up state.
  function automatic logic [HC_W-1:0] lfsr_next(input logic [HC_W-1:0] q);
    return {q[4:0], ~(q[5] ^ q[4])};
  endfunction

  // State reached after hcount-1 steps from zero; the step after it wraps to zero.
  function automatic logic [HC_W-1:0] hc_term(input int hcount);
    logic [HC_W-1:0] q;
    q = '0;
    for (int i = 0; i < hcount - 1; i++) q = lfsr_next(q);
    return q;
  endfunction

  localparam logic [HC_W-1:0] HC_TERM = hc_term(57);

endpackage

// File: rtl/tia_hpoly.sv
// 6-bit polynomial counter with terminal-count wrap and synchronous clear.
// Shared by the horizontal, vertical and object position counters.
module tia_hpoly
  import tia_hphase_pkg::*;
#(
  parameter logic [HC_W-1:0] TERM = HC_TERM
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            step_i,
  input  logic            clr_i,
  output logic [HC_W-1:0] q_o,
  output logic            zero_o
);

  logic [HC_W-1:0] q_q, q_d;

  // Clear and terminal wrap both land on zero, so a coincident pair is a single return.
  always_comb begin
    q_d = q_q;
    if (step_i) begin
      if (clr_i || (q_q == TERM)) q_d = '0;
      else                        q_d = lfsr_next(q_q);
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o    = q_q;
  assign zero_o = (q_q == '0);

endmodule

// File: rtl/tia_hphase_gen.sv
// Two-phase h1/h2 strobe generator for the D1 delay chains, plus the
// horizontal polynomial counter stepped once per phase cycle.
module tia_hphase_gen
  import tia_hphase_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int HCOUNT = 57
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            rsync,
  output logic            h1,
  output logic            h2,
  output logic [HC_W-1:0] hc,
  output logic            hwrap
);

  localparam int              H2_SLOT = DIV / 2;
  localparam logic [DIV-1:0]  PH_RST  = {1'b1, {(DIV-1){1'b0}}};
  localparam logic [HC_W-1:0] TERM    = hc_term(HCOUNT);

  logic [DIV-1:0] ph_q, ph_d;
  logic           sync_q, sync_d;
  logic           hwrap_q, hwrap_d;
  logic           step, hc_zero;

  // Counter steps on the edge that leaves the h2 slot.
  assign step = run & ph_q[H2_SLOT];

  // Phase rotation, resync latch and wrap flag next-state.
  always_comb begin
    ph_d   = run ? {ph_q[DIV-2:0], ph_q[DIV-1]} : ph_q;
    sync_d = sync_q;
    if (step)       sync_d = 1'b0;
    else if (rsync) sync_d = 1'b1;
    // Entering slot 0 never coincides with a counter step (DIV >= 4),
    // so the current zero flag is the one seen during the h1 cycle.
    hwrap_d = ph_d[0] & hc_zero;
  end

  // Phase, sync-pending and wrap registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q    <= PH_RST;
      sync_q  <= 1'b0;
      hwrap_q <= 1'b0;
    end else begin
      ph_q    <= ph_d;
      sync_q  <= sync_d;
      hwrap_q <= hwrap_d;
    end
  end

  tia_hpoly #(.TERM(TERM)) u_hpoly (
    .clk_i  (clk),
    .rst_i  (reset),
    .step_i (step),
    .clr_i  (sync_q | rsync),
    .q_o    (hc),
    .zero_o (hc_zero)
  );

  // Strobes are flop outputs gated only by run.
  assign h1    = ph_q[0]       & run;
  assign h2    = ph_q[H2_SLOT] & run;
  assign hwrap = hwrap_q       & run;

endmodule

// File: tb/tb_tia_hphase_gen.sv
module tb_tia_hphase_gen;
  localparam int DIV = 4;
  localparam int HCOUNT = 57;

  typedef struct packed {
    logic       h1;
    logic       h2;
    logic [5:0] hc;
    logic       wrap;
  } exp_t;

  logic clk = 0, reset = 1, run = 1, rsync = 0;
  logic h1, h2, hwrap;
  logic [5:0] hc;

  int vectors = 0, errors = 0;
  int cycle = 0;
  exp_t sb[$];
  int wq[$];

  // reference model state
  int m_ph = DIV - 1;
  logic [5:0] m_hc = '0;
  logic [5:0] term;
  bit m_pend = 0;

  tia_hphase_gen #(.DIV(DIV), .HCOUNT(HCOUNT)) dut (
    .clk(clk), .reset(reset), .run(run), .rsync(rsync),
    .h1(h1), .h2(h2), .hc(hc), .hwrap(hwrap)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ref_next(input logic [5:0] q);
    logic fb;
    fb = (q[5] == q[4]);
    return {q[4:0], fb};
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ph = DIV - 1; m_hc = '0; m_pend = 0; cycle = 0;
  endtask

  // Called at the falling edge: drive, predict, wait one edge, compare.
  task automatic cyc(input logic r, input logic rs);
    exp_t e;
    bit st;
    run = r; rsync = rs;
    st = r && (m_ph == DIV/2);
    if (st) begin
      if (m_pend || rs || m_hc == term) m_hc = '0;
      else m_hc = ref_next(m_hc);
      m_pend = 0;
    end else if (rs) m_pend = 1;
    if (r) m_ph = (m_ph + 1) % DIV;
    e.h1 = r && m_ph == 0;
    e.h2 = r && m_ph == DIV/2;
    e.hc = m_hc;
    e.wrap = e.h1 && m_hc == 0;
    sb.push_back(e);
    @(posedge clk); #1;
    cycle++;
    e = sb.pop_front();
    check("h1", int'(h1), int'(e.h1));
    check("h2", int'(h2), int'(e.h2));
    check("hc", int'(hc), int'(e.hc));
    check("hwrap", int'(hwrap), int'(e.wrap));
    check("no_overlap", int'(h1 & h2), 0);
    if (hwrap === 1'b1) wq.push_back(cycle);
    @(negedge clk);
    rsync = 0;
  endtask

  initial begin
    int exp_wraps[7] = '{1, 229, 457, 501, 729, 960, 1188};
    int guard;
    term = '0;
    for (int i = 0; i < HCOUNT - 1; i++) term = ref_next(term);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_h1", int'(h1), 0);
    check("rst_h2", int'(h2), 0);
    check("rst_hc", int'(hc), 0);
    check("rst_hwrap", int'(hwrap), 0);
    @(negedge clk);
    reset = 0;
    model_reset();

    // scenarios 1-2: free run past two wraps, then to hc = 10th state at cycle 497
    while (cycle < 497) cyc(1, 0);
    // scenario 3: rsync during the h1 cycle (edge 498 is not a step edge)
    cyc(1, 1);
    while (cycle < 730) cyc(1, 0);
    // scenario 4: stall three cycles in slot 1
    repeat (3) cyc(0, 0);
    cyc(1, 0);
    check("stall_h2", int'(h2), 1);
    // scenario 5: rsync on the terminal-count step edge
    guard = 0;
    while (!(m_ph == DIV/2 && m_hc == term) && guard < 400) begin
      cyc(1, 0); guard++;
    end
    check("term_reached", guard < 400 ? 1 : 0, 1);
    check("hc_at_term", int'(hc), int'(term));
    cyc(1, 1);
    check("term_rsync_hc", int'(hc), 0);
    while (cycle < 1194) cyc(1, 0);

    check("wrap_count", wq.size(), 7);
    for (int i = 0; i < 7; i++)
      check("wrap_cycle", (i < wq.size()) ? wq[i] : -1, exp_wraps[i]);

    // scenario 6: async reset mid-line while h2 is high and hc nonzero
    check("pre_rst_h2", int'(h2), 1);
    check("pre_rst_hc_nz", int'(hc != 0), 1);
    #2 reset = 1;
    #1;
    check("async_h1", int'(h1), 0);
    check("async_h2", int'(h2), 0);
    check("async_hc", int'(hc), 0);
    check("async_hwrap", int'(hwrap), 0);
    @(negedge clk);
    reset = 0;
    model_reset();
    wq.delete();
    repeat (12) cyc(1, 0);
    check("restart_wrap", (wq.size() > 0) ? wq[0] : -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d", cycle);
    $fatal(1, "timeout");
  end
endmodule
